// File: rtl/aurora_rx_32to16_adapter.sv
// rtl/aurora_rx_32to16_adapter.sv - Aurora RX 32-bit to 16-bit stream adapter with input FIFO, NFC XOFF and overflow tracking
module aurora_rx_32to16_adapter #(
  parameter int FIFO_DEPTH  = 16,
  parameter int XOFF_THRESH = 10,
  parameter int XON_THRESH  = 4
) (
  input  logic        user_clk,
  input  logic        ur_ch_reset,
  input  logic [0:31] s_axis_rx_tdata,
  input  logic [0:3]  s_axis_rx_tkeep,
  input  logic        s_axis_rx_tvalid,
  input  logic        s_axis_rx_tlast,
  input  logic        s_axis_rx_tuser,
  output logic [0:15] m_axis_tdata,
  output logic [0:1]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic        nfc_xoff,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] XOFF_C  = CW'(XOFF_THRESH);
  localparam logic [CW-1:0] XON_C   = CW'(XON_THRESH);

  typedef struct packed {
    logic [0:31] data;
    logic [0:3]  keep;
    logic        last;
    logic        user;
  } entry_t;

  typedef enum logic {
    HI = 1'b0,
    LO = 1'b1
  } half_t;

  entry_t          mem_q [FIFO_DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   occ_q, occ_d;
  half_t           half_q, half_d;
  logic            drop_pending_q, drop_pending_d;
  logic            xoff_q, xoff_d;
  logic            overflow_q, overflow_d;

  entry_t          head;
  entry_t          wr_entry;
  logic            wr_en;
  logic            drop;
  logic            out_valid;
  logic            handshake;
  logic            head_has_lo;
  logic            final_beat;
  logic            pop;

  // Write-side qualification: fullness is judged on registered occupancy only
  always_comb begin
    wr_en         = s_axis_rx_tvalid && (occ_q < DEPTH_C);
    drop          = s_axis_rx_tvalid && !(occ_q < DEPTH_C);
    wr_entry.data = s_axis_rx_tdata;
    wr_entry.keep = s_axis_rx_tkeep;
    wr_entry.last = s_axis_rx_tlast;
    // A frame that lost a word is flagged as errored on its closing word
    wr_entry.user = s_axis_rx_tuser | (drop_pending_q & s_axis_rx_tlast);
  end

  // Head-of-FIFO decode and pop decision
  always_comb begin
    head        = mem_q[rd_ptr_q];
    out_valid   = (occ_q != '0);
    handshake   = out_valid && m_axis_tready;
    head_has_lo = |head.keep[2:3];
    final_beat  = (half_q == LO) || !head_has_lo;
    pop         = handshake && final_beat;
  end

  // Entry storage; contents are don't-care until written so no reset
  always_ff @(posedge user_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Drop tracking, sticky overflow and XOFF hysteresis next-state
  always_comb begin
    drop_pending_d = drop_pending_q;
    overflow_d     = overflow_q | drop;
    xoff_d         = xoff_q;
    if (drop) begin
      drop_pending_d = 1'b1;
    end else if (wr_en && s_axis_rx_tlast) begin
      drop_pending_d = 1'b0;
    end
    if (occ_q >= XOFF_C) begin
      xoff_d = 1'b1;
    end else if (occ_q <= XON_C) begin
      xoff_d = 1'b0;
    end
  end

  // Datapath and flag registers
  always_ff @(posedge user_clk or posedge ur_ch_reset) begin
    if (ur_ch_reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      occ_q          <= '0;
      drop_pending_q <= 1'b0;
      xoff_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      occ_q          <= occ_d;
      drop_pending_q <= drop_pending_d;
      xoff_q         <= xoff_d;
      overflow_q     <= overflow_d;
    end
  end

  // Half-select state register
  always_ff @(posedge user_clk or posedge ur_ch_reset) begin
    if (ur_ch_reset) begin
      half_q <= HI;
    end else begin
      half_q <= half_d;
    end
  end

  // Half-select next state: step to LO only when the head carries a second halfword
  always_comb begin
    half_d = half_q;
    if (handshake) begin
      case (half_q)
        HI:      half_d = head_has_lo ? LO : HI;
        LO:      half_d = HI;
        default: half_d = HI;
      endcase
    end
  end

  // Output decode from half-select state and head entry
  always_comb begin
    m_axis_tvalid = out_valid;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    if (out_valid) begin
      if (half_q == HI) begin
        m_axis_tdata = head.data[0:15];
        m_axis_tkeep = head.keep[0:1];
      end else begin
        m_axis_tdata = head.data[16:31];
        m_axis_tkeep = head.keep[2:3];
      end
    end
    m_axis_tlast = out_valid && final_beat && head.last;
    m_axis_tuser = m_axis_tlast && head.user;
    nfc_xoff     = xoff_q;
    overflow     = overflow_q;
  end

endmodule

// File: tb/tb_aurora_rx_32to16_adapter.sv
// tb/tb_aurora_rx_32to16_adapter.sv - self-checking bench for aurora_rx_32to16_adapter
module tb_aurora_rx_32to16_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] s_tdata;
  logic [0:3]  s_tkeep;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tuser;
  logic [0:15] m_tdata;
  logic [0:1]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tready;
  logic        xoff;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_en  = 0;

  always #5 clk = ~clk;

  aurora_rx_32to16_adapter #(
    .FIFO_DEPTH(16), .XOFF_THRESH(10), .XON_THRESH(4)
  ) dut (
    .user_clk(clk), .ur_ch_reset(rst),
    .s_axis_rx_tdata(s_tdata), .s_axis_rx_tkeep(s_tkeep),
    .s_axis_rx_tvalid(s_tvalid), .s_axis_rx_tlast(s_tlast),
    .s_axis_rx_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .nfc_xoff(xoff), .overflow(ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of entries expressed as a queue of output halfword beats
  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  keep;
    logic        last;
    logic        user;
    logic        eoe;
  } beat_t;

  beat_t beats[$];
  int    m_occ  = 0;
  bit    m_ovf  = 0;
  bit    m_pend = 0;
  bit    m_xoff = 0;

  always @(negedge clk) begin
    if (rst) begin
      beats.delete();
      m_occ = 0; m_ovf = 0; m_pend = 0; m_xoff = 0;
    end
    check("m_tvalid", m_tvalid, (m_occ != 0));
    check("overflow", ovf, m_ovf);
    check("nfc_xoff", xoff, m_xoff);
    if (m_occ != 0 && beats.size() > 0) begin
      check("m_tdata", m_tdata, beats[0].data);
      check("m_tkeep", m_tkeep, beats[0].keep);
      check("m_tlast", m_tlast, beats[0].last);
      check("m_tuser", m_tuser, beats[0].user);
    end
    if (!rst) begin
      int    occ_b;
      beat_t b;
      logic  u;
      occ_b = m_occ;
      if (occ_b != 0 && m_tready) begin
        b = beats.pop_front();
        if (b.eoe) m_occ--;
      end
      if (s_tvalid) begin
        if (occ_b < 16) begin
          u = s_tuser | (m_pend & s_tlast);
          if (s_tlast) m_pend = 0;
          if (s_tkeep[2:3] != 2'b00) begin
            beats.push_back({s_tdata[0:15], s_tkeep[0:1], 1'b0, 1'b0, 1'b0});
            beats.push_back({s_tdata[16:31], s_tkeep[2:3], s_tlast, s_tlast & u, 1'b1});
          end else begin
            beats.push_back({s_tdata[0:15], s_tkeep[0:1], s_tlast, s_tlast & u, 1'b1});
          end
          m_occ++;
        end else begin
          m_ovf  = 1;
          m_pend = 1;
        end
      end
      if (occ_b >= 10) m_xoff = 1;
      else if (occ_b <= 4) m_xoff = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_en) m_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_word(input logic [0:31] d, input logic [0:3] k, input logic l, input logic u);
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (m_tvalid && n < budget) begin
      tick();
      n++;
    end
    check(name, m_tvalid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] bc;
    bit         found;
    rst = 1'b1; s_tdata = '0; s_tkeep = '0; s_tvalid = 0; s_tlast = 0; s_tuser = 0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", m_tvalid, 1'b0);
    rst = 1'b0;

    // Full word splits into two halfwords, tlast on the second
    drive_word(32'h11223344, 4'b1111, 1'b1, 1'b0);
    @(negedge clk);
    check("w1_hi_data", m_tdata, 16'h1122);
    check("w1_hi_last", m_tlast, 1'b0);
    @(negedge clk);
    check("w1_lo_data", m_tdata, 16'h3344);
    check("w1_lo_keep", m_tkeep, 2'b11);
    check("w1_lo_last", m_tlast, 1'b1);
    check("w1_lo_user", m_tuser, 1'b0);
    tick();

    // One-halfword tail pops after a single beat
    drive_word(32'hABCD0000, 4'b1100, 1'b1, 1'b1);
    @(negedge clk);
    check("w2_data", m_tdata, 16'hABCD);
    check("w2_keep", m_tkeep, 2'b11);
    check("w2_last", m_tlast, 1'b1);
    check("w2_user", m_tuser, 1'b1);
    @(negedge clk);
    check("w2_popped", m_tvalid, 1'b0);
    tick();

    // Fill with the sink stalled: XOFF, then drop of the 17th word
    m_tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive_word(32'h0100_0000 + i, 4'b1111, 1'b0, 1'b0);
      if (i == 9)  check("xoff_before", xoff, 1'b0);
      if (i == 10) check("xoff_after", xoff, 1'b1);
    end
    check("ovf_set", ovf, 1'b1);
    m_tready = 1'b1;
    repeat (4) tick();
    drive_word(32'h5555AAAA, 4'b1111, 1'b1, 1'b0);
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (m_tvalid && m_tlast) begin
        check("drop_tuser", m_tuser, 1'b1);
        found = 1;
      end
    end
    check("drop_tlast_seen", found, 1'b1);
    tick();
    wait_empty("drain1", 200);
    check("xoff_cleared", xoff, 1'b0);

    // Reset while in LO with five buffered entries
    m_tready = 1'b0;
    for (int k = 0; k < 5; k++) drive_word(32'hA000B000 + k, 4'b1111, 1'b0, 1'b0);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    check("lo_data", m_tdata, 16'hB000);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_xoff", xoff, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    tick();
    rst = 1'b0;
    m_tready = 1'b1;
    drive_word(32'hCAFEBEEF, 4'b1111, 1'b1, 1'b0);
    @(negedge clk);
    check("post_rst_hi", m_tdata, 16'hCAFE);
    check("post_rst_last", m_tlast, 1'b0);
    tick();

    // Back-to-back 3-word frames with random sink back-pressure
    rand_en = 1;
    bc = 8'h00;
    for (int f = 0; f < 20; f++) begin
      for (int w = 0; w < 3; w++) begin
        logic [0:3] k;
        k = 4'b1111;
        if (w == 2) k = (f % 3 == 0) ? 4'b1111 : (f % 3 == 1) ? 4'b1100 : 4'b0000;
        drive_word({bc, bc + 8'd1, bc + 8'd2, bc + 8'd3}, k, (w == 2), (w == 2) && (f % 5 == 0));
        bc = bc + 8'd4;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    rand_en = 0;
    m_tready = 1'b1;
    wait_empty("drain2", 500);
    check("model_empty", beats.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
